// File: rtl/result_ser_pkg.sv
// Shared types and helpers for the result frame serializer.
// Width localparams below describe the default configuration; the top derives its own.
package result_ser_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_CLK_DIV   = 4;
   localparam int DEF_PARITY_EN = 1;
   localparam int BIT_CNT_W     = $clog2(DEF_DATA_W);
   localparam int DIV_CNT_W     = $clog2(DEF_CLK_DIV + 1);
   localparam int POP_MAX_W     = 64;

   // Callers zero-extend their word; supports result words up to POP_MAX_W bits.
   function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < POP_MAX_W; i++) begin
         n = n + 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/result_frame_serializer_bit_period_timer.sv
// Bit period timer: counts 0..CLK_DIV-1 while running and flags the last and
// second-to-last cycle of each serial bit.
module bit_period_timer #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_restart,
   output logic o_bit_end,
   output logic o_pre_end
);

   localparam int CNT_W = $clog2(CLK_DIV + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_restart || r_cnt == LAST_CNT) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_bit_end = !i_restart && (r_cnt == LAST_CNT);

   // A one-cycle bit has no preceding cycle to flag.
   generate
      if (CLK_DIV >= 2) begin : g_pre
         assign o_pre_end = !i_restart && (r_cnt == CNT_W'(CLK_DIV - 2));
      end else begin : g_no_pre
         assign o_pre_end = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/result_frame_serializer.sv
// Accepts result words over valid/ready, reports their ones count and shifts
// them out as start / data MSB-first / optional even parity / stop frames.
module result_frame_serializer
   import result_ser_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int CLK_DIV   = DEF_CLK_DIV,
   parameter int PARITY_EN = DEF_PARITY_EN
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_W-1:0]             in_data,
   output logic                          ser_out,
   output logic                          ser_busy,
   output logic                          frame_done,
   output logic [$clog2(DATA_W+1)-1:0]   ones_count
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int IDX_W = $clog2(DATA_W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   state_t              r_state;
   logic [DATA_W-1:0]   r_shift;
   logic                r_parity;
   logic [IDX_W-1:0]    r_idx;
   logic                r_ser_out;
   logic                r_busy;
   logic                r_frame_done;
   logic [CNT_W-1:0]    r_ones;

   state_t              w_state_next;
   logic                w_capture;
   logic                w_bit_end;
   logic                w_pre_end;
   logic                w_done_next;

   bit_period_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_restart (r_state == IDLE),
      .o_bit_end (w_bit_end),
      .o_pre_end (w_pre_end)
   );

   assign in_ready  = rst_n && (r_state == IDLE);
   assign w_capture = in_valid && in_ready;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:   if (w_capture) w_state_next = START;
         START:  if (w_bit_end) w_state_next = DATA;
         DATA:   if (w_bit_end && r_idx == LAST_IDX)
                    w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
         PARITY: if (w_bit_end) w_state_next = STOP;
         STOP:   if (w_bit_end) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // frame_done is registered, so it is raised one cycle ahead of STOP's last cycle.
   assign w_done_next = (w_state_next == STOP) &&
                        ((CLK_DIV == 1) ? (r_state != STOP)
                                        : (r_state == STOP && w_pre_end));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_shift      <= '0;
         r_parity     <= 1'b0;
         r_idx        <= '0;
         r_ser_out    <= 1'b1;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_ones       <= '0;
      end else begin
         r_state      <= w_state_next;
         r_busy       <= (w_state_next != IDLE);
         r_frame_done <= w_done_next;
         case (r_state)
            IDLE: begin
               r_ser_out <= 1'b1;
               if (w_capture) begin
                  r_shift   <= in_data;
                  r_parity  <= ^in_data;
                  r_ones    <= CNT_W'(popcount(POP_MAX_W'(in_data)));
                  r_idx     <= '0;
                  r_ser_out <= 1'b0;
               end
            end
            START: begin
               if (w_bit_end) r_ser_out <= r_shift[DATA_W-1];
            end
            DATA: begin
               if (w_bit_end) begin
                  if (r_idx == LAST_IDX) begin
                     r_ser_out <= (PARITY_EN != 0) ? r_parity : 1'b1;
                  end else begin
                     // The next MSB is presented while the register shifts under it.
                     r_shift   <= r_shift << 1;
                     r_idx     <= r_idx + IDX_W'(1);
                     r_ser_out <= r_shift[DATA_W-2];
                  end
               end
            end
            PARITY: begin
               if (w_bit_end) r_ser_out <= 1'b1;
            end
            STOP: begin
               r_ser_out <= 1'b1;
            end
            default: r_ser_out <= 1'b1;
         endcase
      end
   end

   assign ser_out    = r_ser_out;
   assign ser_busy   = r_busy;
   assign frame_done = r_frame_done;
   assign ones_count = r_ones;

endmodule

// File: tb/tb_result_frame_serializer.sv
// Self-checking bench: a queue-based frame model predicts every output each cycle,
// plus directed literal expectations for the documented scenarios.
module tb_result_frame_serializer;

   localparam int DW = 8;
   localparam int CD = 2;
   localparam int PE = 1;
   localparam int FL = (2 + DW + PE) * CD;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       ser_out;
   logic       ser_busy;
   logic       frame_done;
   logic [3:0] ones_count;

   int checks = 0;
   int passes = 0;

   bit q[$];
   int m_ones = 0;
   int cyc    = 0;
   int cap_cyc[$];
   bit chk_en = 0;
   bit rec_en = 0;
   bit rec_ser[$];
   bit rec_done[$];

   result_frame_serializer #(
      .DATA_W    (DW),
      .CLK_DIV   (CD),
      .PARITY_EN (PE)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .ser_out    (ser_out),
      .ser_busy   (ser_busy),
      .frame_done (frame_done),
      .ones_count (ones_count)
   );

   always #5 clk = ~clk;

   function automatic int pc(input logic [7:0] d);
      int n = 0;
      for (int i = 0; i < DW; i++) n += int'(d[i]);
      return n;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
   endtask

   // Expected line level for every cycle of a frame, in order.
   task automatic push_frame(input logic [7:0] d);
      bit fb[$];
      fb.push_back(1'b0);
      for (int i = DW - 1; i >= 0; i--) fb.push_back(d[i]);
      if (PE != 0) fb.push_back(bit'(pc(d) % 2));
      fb.push_back(1'b1);
      foreach (fb[k]) for (int r = 0; r < CD; r++) q.push_back(fb[k]);
   endtask

   task automatic model_update();
      bit was_empty;
      cyc++;
      if (!rst_n) begin
         q.delete();
         m_ones = 0;
      end else begin
         was_empty = (q.size() == 0);
         if (!was_empty) void'(q.pop_front());
         if (was_empty && in_valid) begin
            push_frame(in_data);
            m_ones = pc(in_data);
            cap_cyc.push_back(cyc);
         end
      end
   endtask

   task automatic check_outputs();
      int exp_ser;
      exp_ser = (q.size() != 0) ? int'(q[0]) : 1;
      chk("ser_out",    int'(ser_out),    exp_ser);
      chk("ser_busy",   int'(ser_busy),   int'(q.size() != 0));
      chk("frame_done", int'(frame_done), int'(q.size() == 1));
      chk("in_ready",   int'(in_ready),   int'(rst_n && q.size() == 0));
      chk("ones_count", int'(ones_count), m_ones);
      if (rec_en) begin
         rec_ser.push_back(ser_out);
         rec_done.push_back(frame_done);
      end
   endtask

   task automatic cycle(input bit v, input logic [7:0] d, input bit r);
      in_valid = v;
      in_data  = d;
      rst_n    = r;
      @(posedge clk);
      model_update();
      @(negedge clk);
      if (chk_en) check_outputs();
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 8'($urandom), 1'b1);
   endtask

   task automatic send(input logic [7:0] d);
      cycle(1'b1, d, 1'b1);
      idle(FL + 2);
   endtask

   // Holds in_valid with d until the model records a capture (bounded).
   task automatic hold_until_capture(input logic [7:0] d);
      int n0;
      int guard;
      n0 = cap_cyc.size();
      guard = 0;
      while (cap_cyc.size() == n0 && guard < 100) begin
         cycle(1'b1, d, 1'b1);
         guard++;
      end
      chk("capture_timeout", cap_cyc.size(), n0 + 1);
   endtask

   initial begin
      logic [10:0] pat;
      int n0;
      int first_done;
      int done_cnt;

      in_valid = 1'b0;
      in_data  = 8'h00;
      rst_n    = 1'b0;
      cycle(1'b0, 8'h00, 1'b0);
      chk_en = 1;
      cycle(1'b1, 8'hAA, 1'b0);
      cycle(1'b0, 8'h00, 1'b0);
      idle(2);

      chk("model_pc_A5", pc(8'hA5), 4);
      chk("model_pc_07", pc(8'h07), 3);

      // 0xA5 frame against a hand-written bit pattern
      rec_en = 1;
      cycle(1'b1, 8'hA5, 1'b1);
      idle(22);
      rec_en = 0;
      pat = 11'b0_10100101_0_1;
      for (int k = 0; k <= 10; k++) begin
         chk("a5_bit_lo", int'(rec_ser[2*k]),   int'(pat[10-k]));
         chk("a5_bit_hi", int'(rec_ser[2*k+1]), int'(pat[10-k]));
      end
      chk("a5_idle_after", int'(rec_ser[22]), 1);
      first_done = -1;
      done_cnt = 0;
      foreach (rec_done[i]) if (rec_done[i]) begin
         done_cnt++;
         if (first_done < 0) first_done = i;
      end
      chk("a5_done_cycle", first_done + 1, 22);
      chk("a5_done_count", done_cnt, 1);
      chk("a5_ones", int'(ones_count), 4);
      idle(2);

      send(8'h07);
      chk("ones_07", int'(ones_count), 3);
      send(8'h00);
      chk("ones_00", int'(ones_count), 0);
      send(8'hFF);
      chk("ones_FF", int'(ones_count), 8);

      // back-to-back with in_valid held high
      n0 = cap_cyc.size();
      hold_until_capture(8'h3C);
      hold_until_capture(8'hC3);
      idle(FL + 2);
      chk("b2b_gap", cap_cyc[n0+1] - cap_cyc[n0], 23);
      chk("b2b_ones", int'(ones_count), 4);

      // new word offered mid-frame
      n0 = cap_cyc.size();
      cycle(1'b1, 8'h5A, 1'b1);
      idle(6);
      hold_until_capture(8'h99);
      idle(FL + 2);
      chk("mid_gap", cap_cyc[n0+1] - cap_cyc[n0], 23);
      chk("mid_ones", int'(ones_count), 4);

      // reset during data bit 4 (cycles 11-12 after capture)
      cycle(1'b1, 8'h3C, 1'b1);
      idle(9);
      cycle(1'b0, 8'h00, 1'b0);
      chk("rst_ser", int'(ser_out), 1);
      chk("rst_busy", int'(ser_busy), 0);
      chk("rst_ones", int'(ones_count), 0);
      chk("rst_ready", int'(in_ready), 0);
      cycle(1'b0, 8'h00, 1'b1);
      chk("rel_ready", int'(in_ready), 1);
      done_cnt = 0;
      for (int i = 0; i < FL; i++) begin
         idle(1);
         if (frame_done) done_cnt++;
      end
      chk("rst_no_done", done_cnt, 0);

      // randomized traffic with occasional resets
      repeat (600) begin
         cycle($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 199) != 0);
      end
      idle(FL + 2);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
